// File: rtl/lock_sequencer.sv
// Canal lock chamber sequencer: outer gate -> fill -> inner gate -> drain.
// Takes one-cycle arrive/depart pulses and queues one arrival behind the current boat.
module lock_sequencer #(
  parameter int GATE_CYCLES = 8,
  parameter int FILL_CYCLES = 16,
  parameter int CW          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arriveSignal,
  input  logic       departSignal,
  output logic       outerGate,
  output logic       innerGate,
  output logic       fillValve,
  output logic       drainValve,
  output logic       waterHigh,
  output logic       pending,
  output logic [7:0] boatCount
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] OPEN_OUT = 3'd1;
  localparam logic [2:0] FILL     = 3'd2;
  localparam logic [2:0] OPEN_IN  = 3'd3;
  localparam logic [2:0] DRAIN    = 3'd4;

  localparam logic [CW-1:0] GATE_LOAD = CW'(GATE_CYCLES - 1);
  localparam logic [CW-1:0] FILL_LOAD = CW'(FILL_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pending_q, pending_d;
  logic [7:0]    boat_count_q, boat_count_d;
  logic          outer_gate_q, inner_gate_q, fill_valve_q, drain_valve_q, water_high_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    boat_count_d = boat_count_q;

    if (state_q != IDLE && arriveSignal) pending_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (arriveSignal || pending_q) begin
          state_d   = OPEN_OUT;
          cnt_d     = GATE_LOAD;
          pending_d = 1'b0;
        end
      end
      OPEN_OUT: begin
        if (cnt_q == '0) begin
          state_d = FILL;
          cnt_d   = FILL_LOAD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FILL: begin
        if (cnt_q == '0) state_d = OPEN_IN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      OPEN_IN: begin
        if (departSignal) begin
          state_d = DRAIN;
          cnt_d   = FILL_LOAD;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d      = IDLE;
          boat_count_d = boat_count_q + 8'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      boat_count_q  <= 8'd0;
      outer_gate_q  <= 1'b0;
      inner_gate_q  <= 1'b0;
      fill_valve_q  <= 1'b0;
      drain_valve_q <= 1'b0;
      water_high_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so all flops update from the same pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      boat_count_q  <= boat_count_d;
      outer_gate_q  <= (state_d == OPEN_OUT);
      inner_gate_q  <= (state_d == OPEN_IN);
      fill_valve_q  <= (state_d == FILL);
      drain_valve_q <= (state_d == DRAIN);
      water_high_q  <= (state_d == OPEN_IN);
    end
  end

  assign outerGate  = outer_gate_q;
  assign innerGate  = inner_gate_q;
  assign fillValve  = fill_valve_q;
  assign drainValve = drain_valve_q;
  assign waterHigh  = water_high_q;
  assign pending    = pending_q;
  assign boatCount  = boat_count_q;

endmodule
